iq_slot_alloc_ctrl: RTL
=======================

# iq_slot_alloc_ctrl

Allocation controller for the integer issue-queue free-slot queue (the 8-entry circular queue of free slot IDs 3, 7, 11, … 31). It shares the queue's single read port between two dispatch lanes using round-robin arbitration. It merges two release sources into the queue's single write port through a 4-entry release buffer, and sequences the queue's clean operation on pipeline flush. It sits between dispatch/commit and the free-slot queue, and drives that queue's Rable/Wable/Din/CriqClean.

## Interface
- SLOTW, 5, width of a slot ID (matches the free-slot queue data width)
- RBDEEP, 4, release buffer depth (power of two, ≥4)

- Clk  in  1  clock, all state on rising edge
- Rest  in  1  reset, asynchronous, active-high
- AllocReq0 / AllocReq1  in  1  lane 0/1 requests one slot this cycle (level)
- AllocGnt0 / AllocGnt1  out  1  combinational grant, at most one high per cycle
- AllocSlot  out  SLOTW  slot ID for the granted lane (= QPreOut), valid only with a grant
- RelVld0 / RelVld1  in  1  release source 0/1 returns a slot
- RelSlot0 / RelSlot1  in  SLOTW  returned slot ID
- RelStall  out  1  release buffer cannot take two more entries
- RelOvf  out  1  sticky: a release was dropped for lack of space
- Flush  in  1  pipeline flush, one or more cycles
- QRable / QWable  out  1  free-slot queue read/write enable
- QDin  out  SLOTW  free-slot queue write data
- QPreOut  in  SLOTW  free-slot queue head
- QEmpty  in  1  free-slot queue empty
- QClean  out  1  free-slot queue clean (reload)

## Operation
- FSM states: RUN and SETTLE. Reset state is RUN.
- RUN → SETTLE when Flush=1. SETTLE → RUN when Flush=0. SETTLE → SETTLE when Flush=1.
- QClean = Flush, combinational, in any state.
- Grant enable: GntEn = (state==RUN) & !Flush & !QEmpty.
- Arbitration, with 1-bit round-robin pointer RrPtr (reset 0 = lane 0 preferred):
  - Both lanes request: grant lane RrPtr; RrPtr ← other lane.
  - Only one lane requests: grant it; RrPtr ← the other lane.
  - No grant issued: RrPtr holds.
- QRable = AllocGnt0 | AllocGnt1. AllocSlot = QPreOut.
- Release buffer: FIFO, RBDEEP entries, occupancy counter Cnt of width log2(RBDEEP)+1.
  - Same-cycle enqueue order: RelSlot0 first, then RelSlot1.
  - Drain: one entry per cycle when state==RUN, !Flush and Cnt>0. Then QWable=1 and QDin = head.
  - No bypass: an entry enqueued at edge N drains at edge N+1 at the earliest.
  - Head and tail pointers wrap modulo RBDEEP.
- RelStall = (RBDEEP − Cnt) < 2, from registered Cnt.
- If a valid release finds no free entry (after counting this cycle's drain), it is dropped and RelOvf sets. RelOvf clears only on reset.
- Flush (Flush=1) takes effect at the next edge:
  - Release buffer emptied (Cnt←0, pointers←0).
  - Releases presented while Flush=1 or in SETTLE are discarded, not counted as overflow. The queue reload reclaims all slots.
- Grant and drain in the same cycle are legal; the queue performs the read and the write concurrently.

## Timing
- Reset values: AllocGnt0/1=0, QRable=0, QWable=0, QClean=0 (Flush low), RelStall=0, RelOvf=0, Cnt=0, RrPtr=0, state RUN.
- Asserting reset mid-operation clears all state immediately. The controller does not drive QClean for reset; the queue resets itself.
- Allocation is zero-latency: grant and slot are valid in the request cycle. The requester consumes them at that edge and must drop its request if it needs no further slot.
- Release-to-queue latency is 1 cycle minimum. Worst case is Cnt cycles queued behind earlier entries.
- Grants are blocked for the Flush cycle(s) plus exactly 1 SETTLE cycle, to allow the queue pointer reload.

## Configuration
- IQALLOC_STAT_EN defined: adds output StatStallCnt[15:0].
  - Increments each cycle where (AllocReq0|AllocReq1) is high and no grant is issued.
  - Saturates at 16'hFFFF; cleared only by reset.
- IQALLOC_STAT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Both lanes request continuously after reset, queue holding 3,7,11,…: required response is Gnt0 with slot 3, Gnt1 with 7, Gnt0 with 11, and so on, strictly alternating. After 8 grants QEmpty=1, no grants issue, and StatStallCnt increments (STAT_EN).
- RelVld0 with slot 7 and RelVld1 with slot 19 in the same cycle, buffer empty: Cnt=2. QWable with QDin=7 on the next cycle, then QDin=19 on the cycle after.
- Releases on both sources every cycle: RelStall rises once Cnt ≥3. A forced release while full is dropped, RelOvf=1, and RelOvf stays set until reset.
- Flush pulsed for 1 cycle with Cnt=3 and lane 0 requesting: QClean=1 and no grant in the Flush cycle. Cnt=0 afterwards, no grant in the SETTLE cycle, and the first grant after that returns slot 3.
- Only lane 1 requests for 2 grants, then both lanes request: the first grant under contention goes to lane 0.
- Reset asserted asynchronously mid-drain: all outputs go to their reset values before the next clock edge, and nothing further is written to the queue.

Source files
------------

// File: rtl/iq_slot_alloc_ctrl.sv
// Free-slot queue allocation controller: round-robin grant of the queue head to two
// dispatch lanes, release buffering into the write port, flush sequencing. Option: IQALLOC_STAT_EN.
module iq_slot_alloc_ctrl #(
  parameter int SLOTW  = 5,
  parameter int RBDEEP = 4
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             AllocReq0,
  input  logic             AllocReq1,
  output logic             AllocGnt0,
  output logic             AllocGnt1,
  output logic [SLOTW-1:0] AllocSlot,
  input  logic             RelVld0,
  input  logic             RelVld1,
  input  logic [SLOTW-1:0] RelSlot0,
  input  logic [SLOTW-1:0] RelSlot1,
  output logic             RelStall,
  output logic             RelOvf,
  input  logic             Flush,
  output logic             QRable,
  output logic             QWable,
  output logic [SLOTW-1:0] QDin,
  input  logic [SLOTW-1:0] QPreOut,
  input  logic             QEmpty,
  output logic             QClean
`ifdef IQALLOC_STAT_EN
  ,
  output logic [15:0]      StatStallCnt
`endif
);

  // state  | meaning
  // RUN    | normal grant and drain operation
  // SETTLE | queue pointer reload in progress, grants and drain blocked
  typedef enum logic {RUN = 1'b0, SETTLE = 1'b1} state_t;

  localparam int PW = $clog2(RBDEEP);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(RBDEEP);

  state_t state, state_nxt;
  logic rr_ptr, rr_nxt;
  logic gnt_en;

  logic [SLOTW-1:0] mem [RBDEEP];
  logic [PW-1:0] wr_ptr, rd_ptr, wr1_ptr;
  logic [CW-1:0] cnt, cnt_nxt, space, space1;
  logic accept, drain, en0, en1, drop;

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state  <= RUN;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    AllocGnt0 = 1'b0;
    AllocGnt1 = 1'b0;
    rr_nxt    = rr_ptr;
    case (state)
      RUN:     state_nxt = Flush ? SETTLE : RUN;
      SETTLE:  state_nxt = Flush ? SETTLE : RUN;
      default: state_nxt = RUN;
    endcase
    if (gnt_en) begin
      if (AllocReq0 && AllocReq1) begin
        AllocGnt0 = !rr_ptr;
        AllocGnt1 = rr_ptr;
        rr_nxt    = !rr_ptr;
      end else if (AllocReq0) begin
        AllocGnt0 = 1'b1;
        rr_nxt    = 1'b1;
      end else if (AllocReq1) begin
        AllocGnt1 = 1'b1;
        rr_nxt    = 1'b0;
      end
    end
  end

  assign gnt_en    = (state == RUN) && !Flush && !QEmpty;
  assign QRable    = AllocGnt0 | AllocGnt1;
  assign AllocSlot = QPreOut;
  assign QClean    = Flush;

  // Free space counts the entry leaving this cycle; releases outside RUN are discarded.
  assign accept  = (state == RUN) && !Flush;
  assign drain   = accept && (cnt != '0);
  assign space   = DEPTH - cnt + CW'(drain);
  assign en0     = accept && RelVld0 && (space != '0);
  assign space1  = space - CW'(en0);
  assign en1     = accept && RelVld1 && (space1 != '0);
  assign drop    = accept && ((RelVld0 && !en0) || (RelVld1 && !en1));
  assign cnt_nxt = cnt + CW'(en0) + CW'(en1) - CW'(drain);
  assign wr1_ptr = wr_ptr + PW'(en0);

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      RelOvf <= 1'b0;
    end else begin
      RelOvf <= RelOvf | drop;
      if (Flush) begin
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        cnt    <= cnt_nxt;
        wr_ptr <= wr_ptr + PW'(en0) + PW'(en1);
        rd_ptr <= rd_ptr + PW'(drain);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (en0) mem[wr_ptr] <= RelSlot0;
    if (en1) mem[wr1_ptr] <= RelSlot1;
  end

  assign QWable   = drain;
  assign QDin     = mem[rd_ptr];
  assign RelStall = (DEPTH - cnt) < CW'(2);

`ifdef IQALLOC_STAT_EN
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest)
      StatStallCnt <= '0;
    else if ((AllocReq0 || AllocReq1) && !QRable && (StatStallCnt != 16'hFFFF))
      StatStallCnt <= StatStallCnt + 16'd1;
  end
`endif

endmodule
